rename_reg_file: RTL

//  Parametrised floating-point register file with per-register rename status (pending flag + producing ROB tag).

---
 rtl/rename_reg_file.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rename_reg_file.sv
// Floating-point register file with per-register rename status (pending flag + producing ROB tag).
// Commit always writes data; dispatch and flush arbitrate the status bits; pend_cnt is registered.
module rename_reg_file #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 32,
    parameter int ROB_W   = 4,
    parameter int NRD     = 4,
    parameter int NDISP   = 2,
    parameter int NWB     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(NREG + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD*AW-1:0]       rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_avail,
    output logic [NRD*ROB_W-1:0]    rd_tag,
    input  logic [NDISP-1:0]        disp_en,
    input  logic [NDISP*AW-1:0]     disp_addr,
    input  logic [NDISP*ROB_W-1:0]  disp_tag,
    input  logic [NWB-1:0]          wb_en,
    input  logic [NWB*AW-1:0]       wb_addr,
    input  logic [NWB*ROB_W-1:0]    wb_tag,
    input  logic [NWB*DATA_W-1:0]   wb_data,
    input  logic                    flush,
    output logic [CW-1:0]           pend_cnt
);

    logic [DATA_W-1:0] data_q [NREG];
    logic [DATA_W-1:0] data_d [NREG];
    logic [ROB_W-1:0]  tag_q  [NREG];
    logic [ROB_W-1:0]  tag_d  [NREG];
    logic [NREG-1:0]   pend_q, pend_d;
    logic [CW-1:0]     pend_cnt_q, pend_cnt_d;

    // Out-of-range addresses and (optionally) r0 are inert for every access.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic ok;
        ok = ({1'b0, a} < (AW+1)'(NREG));
        if (ZERO_R0 != 0 && a == '0) ok = 1'b0;
        return ok;
    endfunction

    always_comb begin
        logic [NREG-1:0] clr;
        logic [AW-1:0]   wa;
        logic [AW-1:0]   da;
        clr    = '0;
        wa     = '0;
        da     = '0;
        data_d = data_q;
        pend_d = pend_q;
        tag_d  = tag_q;
        // Ascending order lets the youngest commit's data land last.
        for (int j = 0; j < NWB; j++) begin
            wa = wb_addr[j*AW +: AW];
            if (wb_en[j] && addr_ok(wa)) begin
                data_d[wa] = wb_data[j*DATA_W +: DATA_W];
                if (pend_q[wa] && wb_tag[j*ROB_W +: ROB_W] == tag_q[wa]) clr[wa] = 1'b1;
            end
        end
        for (int r = 0; r < NREG; r++) begin
            if (clr[r]) begin
                pend_d[r] = 1'b0;
                tag_d[r]  = '0;
            end
        end
        if (flush) begin
            pend_d = '0;
            for (int r = 0; r < NREG; r++) tag_d[r] = '0;
        end else begin
            // Applied after the clear so a new producer outranks a retiring one.
            for (int i = 0; i < NDISP; i++) begin
                da = disp_addr[i*AW +: AW];
                if (disp_en[i] && addr_ok(da)) begin
                    pend_d[da] = 1'b1;
                    tag_d[da]  = disp_tag[i*ROB_W +: ROB_W];
                end
            end
        end
        pend_cnt_d = '0;
        for (int r = 0; r < NREG; r++) pend_cnt_d = pend_cnt_d + CW'(pend_d[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '{default: '0};
            tag_q      <= '{default: '0};
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            data_q     <= data_d;
            tag_q      <= tag_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    always_comb begin
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] dat;
        logic              avail;
        logic [ROB_W-1:0]  tg;
        rd_data  = '0;
        rd_avail = '0;
        rd_tag   = '0;
        ra       = '0;
        dat      = '0;
        avail    = 1'b1;
        tg       = '0;
        for (int k = 0; k < NRD; k++) begin
            ra    = rd_addr[k*AW +: AW];
            dat   = '0;
            avail = 1'b1;
            tg    = '0;
            if (addr_ok(ra)) begin
                dat   = data_q[ra];
                avail = !pend_q[ra];
                tg    = pend_q[ra] ? tag_q[ra] : '0;
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWB; j++) begin
                        if (wb_en[j] && wb_addr[j*AW +: AW] == ra) begin
                            dat = wb_data[j*DATA_W +: DATA_W];
                            if (pend_q[ra] && wb_tag[j*ROB_W +: ROB_W] == tag_q[ra]) begin
                                avail = 1'b1;
                                tg    = '0;
                            end
                        end
                    end
                end
            end
            rd_data[k*DATA_W +: DATA_W] = dat;
            rd_avail[k]                 = avail;
            rd_tag[k*ROB_W +: ROB_W]    = tg;
        end
    end

endmodule
